// File: rtl/apuf_pkg.sv
// Shared definitions for the arbiter-PUF response reader: default line length,
// controller state encoding and counter sizing.
package apuf_pkg;

    localparam int APUF_LINE_LENGTH = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RACE   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Counters must hold the value NUM_EVAL itself.
    function automatic int cnt_width(input int num_eval);
        return $clog2(num_eval + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/apuf_arbiter.sv
// Arbiter flop resolving which delay-line path arrives first, followed by a
// two-flop synchronizer into the clk domain.
module apuf_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic line_out_1,
    input  logic line_out_2,
    output logic arb_bit
);

    logic race_q;
    logic sync1_q;
    logic sync2_q;

    // Path 2 clocks the flop: a 1 is captured only if path 1 was already high.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge line_out_2 or negedge rst_n) begin
        if (!rst_n) begin
            race_q <= 1'b0;
        end else begin
            race_q <= line_out_1;
        end
    end

    // The race flop may go metastable on coincident edges; two stages give it time to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= race_q;
            sync2_q <= sync1_q;
        end
    end

    assign arb_bit = sync2_q;

endmodule

// File: rtl/apuf_response_reader.sv
// Runs NUM_EVAL arbiter-PUF races on a registered challenge and returns the
// majority-voted response bit with a one-cycle valid pulse.
module apuf_response_reader
    import apuf_pkg::*;
#(
    parameter  int LINE_LENGTH   = APUF_LINE_LENGTH,
    parameter  int NUM_EVAL      = 5,
    parameter  int SETTLE_CYCLES = 4,
    parameter  int RACE_CYCLES   = 4,
    localparam int CNT_W         = cnt_width(NUM_EVAL)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LINE_LENGTH-1:0] challenge_in,
    input  logic                   line_out_1,
    input  logic                   line_out_2,
    output logic                   launch,
    output logic [LINE_LENGTH-1:0] challenge,
    output logic                   busy,
    output logic                   resp_valid,
    output logic                   response,
    output logic [CNT_W-1:0]       ones_count
);

    localparam int TMR_W = $clog2(max_int(SETTLE_CYCLES, RACE_CYCLES) + 1);

    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] RACE_LOAD   = TMR_W'(RACE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] EVAL_LAST   = CNT_W'(NUM_EVAL - 1);
    localparam logic [CNT_W-1:0] MAJORITY    = CNT_W'(NUM_EVAL / 2);

    state_e                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [CNT_W-1:0]       eval_cnt_q, eval_cnt_d;
    logic [CNT_W-1:0]       ones_cnt_q, ones_cnt_d;
    logic [LINE_LENGTH-1:0] challenge_q, challenge_d;
    logic                   launch_q, launch_d;
    logic                   busy_q, busy_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   response_q, response_d;
    logic [CNT_W-1:0]       ones_count_q, ones_count_d;
    logic                   arb_bit;

    apuf_arbiter u_arbiter (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_out_1 (line_out_1),
        .line_out_2 (line_out_2),
        .arb_bit    (arb_bit)
    );

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        eval_cnt_d   = eval_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        challenge_d  = challenge_q;
        resp_valid_d = 1'b0;
        response_d   = response_q;
        ones_count_d = ones_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SETTLE;
                    timer_d     = SETTLE_LOAD;
                    eval_cnt_d  = '0;
                    ones_cnt_d  = '0;
                    challenge_d = challenge_in;
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = ST_RACE;
                    timer_d = RACE_LOAD;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            ST_RACE: begin
                if (timer_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            ST_SAMPLE: begin
                ones_cnt_d = ones_cnt_q + CNT_W'(arb_bit);
                eval_cnt_d = eval_cnt_q + CNT_ONE;
                if (eval_cnt_q == EVAL_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETTLE;
                    timer_d = SETTLE_LOAD;
                end
            end
            ST_DONE: begin
                resp_valid_d = 1'b1;
                response_d   = (ones_cnt_q > MAJORITY);
                ones_count_d = ones_cnt_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Decoded from the next state so launch leaves a flop and cannot glitch.
        launch_d = (state_d == ST_RACE) || (state_d == ST_SAMPLE);
        busy_d   = (state_d != ST_IDLE) || resp_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            eval_cnt_q   <= '0;
            ones_cnt_q   <= '0;
            challenge_q  <= '0;
            launch_q     <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            response_q   <= 1'b0;
            ones_count_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            eval_cnt_q   <= eval_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            challenge_q  <= challenge_d;
            launch_q     <= launch_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            response_q   <= response_d;
            ones_count_q <= ones_count_d;
        end
    end

    assign launch     = launch_q;
    assign challenge  = challenge_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign response   = response_q;
    assign ones_count = ones_count_q;

endmodule
